// File: rtl/collector_pkg.sv
// Shared types and helpers for the result collector: FSM states, channel-index width, round-robin search.
// No logic of its own; imported by result_collector and collector_fifo.
// Round-robin search is combinational; callers register its result.
package collector_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, SETTLE} collector_state_t;

  localparam int NCHAN_MAX = 63;
  localparam int MASK_W    = NCHAN_MAX + 1;

  // Width of a 1-based channel index (0 is reserved for "no channel").
  function automatic int chan_width(input int nchan);
    return $clog2(nchan + 1);
  endfunction

  // First set bit of mask after ptr, wrapping nchan back to 1; 0 when nothing is set.
  function automatic logic [5:0] rr_pick(input logic [MASK_W-1:0] mask,
                                         input logic [5:0]        ptr,
                                         input int                nchan);
    logic [5:0] pick;
    int         c;
    pick = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = NCHAN_MAX; k >= 1; k--) begin
      if (k <= nchan) begin
        c = int'(ptr) + k;
        if (c > nchan) c = c - nchan;
        if (mask[6'(c)]) pick = 6'(c);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/collector_fifo.sv
// Synchronous FIFO holding collected {channel, word} entries, with occupancy output.
// Latency: a push is visible at head_dat / count the cycle after it is presented.
// No internal flow control: the caller only pushes with a free slot and pops when count is non-zero.
module collector_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/result_collector.sv
// Round-robin collector: drains one serial result word per grant from NCHAN channels into an output FIFO.
// Latency: word visible on out_valid WORD_BITS+3 cycles after the grant; RESULT_COLLECTOR_STATS_EN adds counters.
// Backpressure: no grant unless the output FIFO has a committed free slot; out_valid/out_ready to the host.
module result_collector
  import collector_pkg::*;
#(
  parameter  int NCHAN         = 24,
  parameter  int WORD_BITS     = 32,
  parameter  int OUT_DEPTH     = 4,
  parameter  int SETTLE_CYCLES = 2,
  localparam int CW            = chan_width(NCHAN)
) (
  input  logic                 fifo_clk,
  input  logic                 fifo_rst_n,
  input  logic [1:NCHAN]       chan_enable,
  input  logic [1:NCHAN]       fifo_empty,
  output logic [1:NCHAN]       fifo_req,
  input  logic [1:NCHAN]       fifo_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 busy
`ifdef RESULT_COLLECTOR_STATS_EN
  ,
  output logic [31:0]          word_count,
  output logic [15:0]          stall_count
`endif
);

  localparam int CNTW = $clog2(WORD_BITS + 1);
  localparam int AW   = $clog2(OUT_DEPTH);
  localparam int SCW  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int FW   = CW + WORD_BITS;

  collector_state_t     state_q;
  collector_state_t     state_d;
  logic [CW-1:0]        ptr_q;
  logic [CW-1:0]        chan_q;
  logic [1:NCHAN]       sel_q;
  logic [WORD_BITS-1:0] shift_q;
  logic [CNTW-1:0]      bit_cnt_q;
  logic [SCW-1:0]       settle_cnt_q;

  logic [MASK_W-1:0]    elig_mask;
  logic [5:0]           pick;
  logic [1:NCHAN]       pick_onehot;
  logic                 any_elig;
  logic                 have_slot;
  logic                 grant;
  logic                 push;
  logic                 pop;
  logic                 serial_bit;
  logic [AW:0]          occ;
  logic [FW-1:0]        head_dat;

  always_comb begin
    elig_mask = '0;
    for (int i = 1; i <= NCHAN; i++) begin
      elig_mask[i] = chan_enable[i] & ~fifo_empty[i];
    end
  end

  assign pick = rr_pick(elig_mask, 6'(ptr_q), NCHAN);

  always_comb begin
    pick_onehot = '0;
    for (int i = 1; i <= NCHAN; i++) begin
      pick_onehot[i] = (pick == 6'(i));
    end
  end

  // Occupancy covers committed entries only, and one word is in flight at most,
  // so a slot seen free at grant time is still free at push time.
  assign any_elig   = |elig_mask;
  assign have_slot  = (occ < (AW+1)'(OUT_DEPTH));
  assign grant      = (state_q == IDLE) && any_elig && have_slot;
  assign serial_bit = |(fifo_bits & sel_q);
  assign pop        = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE:    if (grant) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == CNTW'(WORD_BITS)) state_d = CAPTURE;
      CAPTURE: begin
        push    = 1'b1;
        state_d = (SETTLE_CYCLES > 0) ? SETTLE : IDLE;
      end
      SETTLE:  if (settle_cnt_q == SCW'(SETTLE_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Bit counter runs 0..WORD_BITS across SHIFT; data trails the request by one cycle,
  // so samples are taken on counts 1..WORD_BITS and the request drops after count WORD_BITS-1.
  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      fifo_req     <= '0;
      sel_q        <= '0;
      ptr_q        <= CW'(NCHAN);
      chan_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            fifo_req  <= pick_onehot;
            sel_q     <= pick_onehot;
            ptr_q     <= CW'(pick);
            chan_q    <= CW'(pick);
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          bit_cnt_q <= bit_cnt_q + CNTW'(1);
          if (bit_cnt_q != '0) shift_q <= (shift_q << 1) | WORD_BITS'(serial_bit);
          if (bit_cnt_q == CNTW'(WORD_BITS - 1)) fifo_req <= '0;
        end
        CAPTURE: settle_cnt_q <= '0;
        SETTLE:  settle_cnt_q <= settle_cnt_q + SCW'(1);
        default: ;
      endcase
    end
  end

  collector_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (fifo_clk),
    .rst_n    (fifo_rst_n),
    .push_vld (push),
    .push_dat ({chan_q, shift_q}),
    .pop_vld  (pop),
    .head_dat (head_dat),
    .count    (occ)
  );

  // Outputs read zero whenever nothing is queued.
  assign out_valid = (occ != '0);
  assign out_chan  = out_valid ? head_dat[FW-1:WORD_BITS] : '0;
  assign out_data  = out_valid ? head_dat[WORD_BITS-1:0]  : '0;
  assign busy      = (state_q != IDLE) || out_valid;

`ifdef RESULT_COLLECTOR_STATS_EN
  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      word_count  <= '0;
      stall_count <= '0;
    end else begin
      if (pop && (word_count != '1)) word_count <= word_count + 32'd1;
      if ((state_q == IDLE) && any_elig && !have_slot && (stall_count != '1))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with NCHAN=24, WORD_BITS=8, OUT_DEPTH=4, SETTLE_CYCLES=2.
// Includes a serial channel model that shifts one bit out the cycle after each request.
module tb_result_collector;

  localparam int NCH    = 24;
  localparam int WB     = 8;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int PERIOD = WB + 3 + SETTLE;

  logic            fifo_clk = 1'b0;
  logic            fifo_rst_n;
  logic [1:NCH]    chan_enable;
  logic [1:NCH]    fifo_empty;
  logic [1:NCH]    fifo_req;
  logic [1:NCH]    fifo_bits;
  logic            out_valid;
  logic            out_ready;
  logic [WB-1:0]   out_data;
  logic [4:0]      out_chan;
  logic            busy;
`ifdef RESULT_COLLECTOR_STATS_EN
  logic [31:0]     word_count;
  logic [15:0]     stall_count;
`endif

  int       words_left [1:NCH];
  int       bitpos     [1:NCH];
  int       sent       [1:NCH];
  logic [7:0] base     [1:NCH];

  int tests = 0;
  int fails = 0;

  result_collector #(
    .NCHAN         (NCH),
    .WORD_BITS     (WB),
    .OUT_DEPTH     (DEPTH),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .fifo_clk    (fifo_clk),
    .fifo_rst_n  (fifo_rst_n),
    .chan_enable (chan_enable),
    .fifo_empty  (fifo_empty),
    .fifo_req    (fifo_req),
    .fifo_bits   (fifo_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .busy        (busy)
`ifdef RESULT_COLLECTOR_STATS_EN
    ,
    .word_count  (word_count),
    .stall_count (stall_count)
`endif
  );

  always #5 fifo_clk = ~fifo_clk;

  function automatic logic [1:NCH] oh(input int c);
    logic [1:NCH] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic refresh_empty();
    for (int c = 1; c <= NCH; c++) fifo_empty[c] = (words_left[c] == 0);
  endtask

  // One clock: a channel requested this cycle presents its next bit after the edge.
  task automatic tick();
    logic [1:NCH] rq;
    logic [7:0]   w;
    rq = fifo_req;
    @(posedge fifo_clk);
    #1;
    for (int c = 1; c <= NCH; c++) begin
      if (rq[c]) begin
        w = 8'(int'(base[c]) + sent[c]);
        fifo_bits[c] = w[7 - bitpos[c]];
        bitpos[c]++;
        if (bitpos[c] == WB) begin
          bitpos[c] = 0;
          sent[c]++;
          words_left[c]--;
        end
      end
    end
    refresh_empty();
  endtask

  task automatic do_reset();
    fifo_rst_n  = 1'b0;
    chan_enable = '0;
    out_ready   = 1'b0;
    fifo_bits   = '0;
    for (int c = 1; c <= NCH; c++) begin
      words_left[c] = 0;
      bitpos[c]     = 0;
      sent[c]       = 0;
      base[c]       = 8'(c * 8);
    end
    refresh_empty();
    repeat (2) tick();
    fifo_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (fifo_req !== '0)    begin fails++; $display("FAIL reset_req: got %h want 0", fifo_req); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", out_data); end
    tests++; if (out_chan !== 5'd0)  begin fails++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_word();
    logic [1:NCH] exp;
    do_reset();
    base[5]       = 8'hA5;
    words_left[5] = 1;
    refresh_empty();
    chan_enable   = '1;
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (t <= 9) begin
        if (t <= 8) exp = oh(5);
        else        exp = '0;
        tests++;
        if (fifo_req !== exp) begin
          fails++; $display("FAIL single_req t%0d: got %h want %h", t, fifo_req, exp);
        end
      end
      if (t == 10) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
      end
      if (t == 11) begin
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", out_valid); end
        tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", out_data); end
        tests++; if (out_chan !== 5'd5)  begin fails++; $display("FAIL single_chan: got %0d want 5", out_chan); end
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_ch [6] = '{3, 7, 24, 3, 7, 24};
    int got;
    int multihot;
    logic [7:0] exp_dat;
    do_reset();
    base[3] = 8'h30; base[7] = 8'h70; base[24] = 8'hF0;
    words_left[3] = 2; words_left[7] = 2; words_left[24] = 2;
    refresh_empty();
    chan_enable = '1;
    out_ready   = 1'b1;
    got = 0;
    multihot = 0;
    for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
      if ($countones(fifo_req) > 1) multihot++;
      if (out_valid === 1'b1) begin
        exp_dat = 8'(int'(base[exp_ch[got]]) + got / 3);
        tests++;
        if (out_chan !== 5'(exp_ch[got])) begin
          fails++; $display("FAIL rr_chan #%0d: got %0d want %0d", got, out_chan, exp_ch[got]);
        end
        tests++;
        if (out_data !== exp_dat) begin
          fails++; $display("FAIL rr_data #%0d: got %h want %h", got, out_data, exp_dat);
        end
        got++;
      end
      tick();
    end
    tests++; if (got != 6)     begin fails++; $display("FAIL rr_count: got %0d words want 6", got); end
    tests++; if (multihot != 0) begin fails++; $display("FAIL rr_onehot: got %0d multi-hot cycles want 0", multihot); end
  endtask

  task automatic test_backpressure();
    int req_cycles;
    int got;
    do_reset();
    base[1]       = 8'h10;
    words_left[1] = 100;
    refresh_empty();
    chan_enable[1] = 1'b1;
    req_cycles = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (fifo_req[1] === 1'b1) req_cycles++;
    end
    tests++; if (req_cycles != 4 * WB) begin fails++; $display("FAIL bp_req_cycles: got %0d want %0d", req_cycles, 4 * WB); end
    tests++; if (fifo_req !== '0)      begin fails++; $display("FAIL bp_req_idle: got %h want 0", fifo_req); end
    tests++; if (out_valid !== 1'b1)   begin fails++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
      if (out_valid === 1'b1) begin
        tests++;
        if (out_data !== 8'(8'h10 + got) || out_chan !== 5'd1) begin
          fails++; $display("FAIL bp_drain #%0d: got ch%0d %h want ch1 %h", got, out_chan, out_data, 8'(8'h10 + got));
        end
        got++;
      end
      tick();
    end
    tests++; if (got != 5) begin fails++; $display("FAIL bp_resume: got %0d words want 5", got); end
  endtask

  task automatic test_mask_wrap();
    int ch1_req;
    int ch2_req;
    int got;
    do_reset();
    base[2]       = 8'h2C;
    words_left[1] = 3;
    words_left[2] = 1;
    refresh_empty();
    chan_enable[2] = 1'b1;
    out_ready      = 1'b1;
    ch1_req = 0; ch2_req = 0; got = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (fifo_req[1] === 1'b1) ch1_req++;
      if (fifo_req[2] === 1'b1) ch2_req++;
      if (out_valid === 1'b1) begin
        got++;
        tests++;
        if (out_chan !== 5'd2 || out_data !== 8'h2C) begin
          fails++; $display("FAIL mask_word: got ch%0d %h want ch2 2c", out_chan, out_data);
        end
      end
      tick();
    end
    tests++; if (ch1_req != 0)  begin fails++; $display("FAIL mask_ch1: got %0d req cycles want 0", ch1_req); end
    tests++; if (ch2_req != WB) begin fails++; $display("FAIL mask_ch2: got %0d req cycles want %0d", ch2_req, WB); end
    tests++; if (got != 1)      begin fails++; $display("FAIL mask_count: got %0d words want 1", got); end
  endtask

  task automatic test_reset_mid_word();
    int got;
    do_reset();
    base[9]       = 8'h9E;
    words_left[9] = 1;
    refresh_empty();
    chan_enable   = '1;
    out_ready     = 1'b1;
    repeat (6) tick();
    tests++; if (fifo_req !== oh(9)) begin fails++; $display("FAIL midrst_pre: got %h want %h", fifo_req, oh(9)); end
    fifo_rst_n = 1'b0;
    #1;
    tests++; if (fifo_req !== '0)    begin fails++; $display("FAIL midrst_req: got %h want 0", fifo_req); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    for (int c = 1; c <= NCH; c++) bitpos[c] = 0;
    base[4]       = 8'h44;
    words_left[4] = 1;
    refresh_empty();
    repeat (2) tick();
    fifo_rst_n = 1'b1;
    tick();
    tests++; if (fifo_req !== oh(4)) begin fails++; $display("FAIL midrst_regrant: got %h want %h", fifo_req, oh(4)); end
    got = 0;
    for (int cyc = 0; cyc < 30 && got == 0; cyc++) begin
      if (out_valid === 1'b1) begin
        got = 1;
        tests++;
        if (out_chan !== 5'd4 || out_data !== 8'h44) begin
          fails++; $display("FAIL midrst_first_word: got ch%0d %h want ch4 44", out_chan, out_data);
        end
      end else begin
        tick();
      end
    end
    tests++; if (got != 1) begin fails++; $display("FAIL midrst_timeout: got %0d words want 1", got); end
  endtask

`ifdef RESULT_COLLECTOR_STATS_EN
  task automatic test_stats();
    int exp_stall;
    do_reset();
    tests++; if (word_count !== 32'd0) begin fails++; $display("FAIL stats_reset: got %0d want 0", word_count); end
    base[1]        = 8'h10;
    words_left[1]  = 100;
    refresh_empty();
    chan_enable[1] = 1'b1;
    repeat (80) tick();
    // Fourth word's grant is at 3*PERIOD; IDLE-while-full starts one PERIOD later.
    exp_stall = 80 - 4 * PERIOD;
    chan_enable = '0;
    out_ready   = 1'b1;
    repeat (10) tick();
    tests++; if (word_count !== 32'd4) begin fails++; $display("FAIL stats_words: got %0d want 4", word_count); end
    tests++;
    if (stall_count !== 16'(exp_stall)) begin
      fails++; $display("FAIL stats_stall: got %0d want %0d", stall_count, exp_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_backpressure();
    test_mask_wrap();
    test_reset_mid_word();
`ifdef RESULT_COLLECTOR_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
